// File: rtl/serdes_64b66b_rx_block_lock_if.sv
// serdes_64b66b_rx_block_lock_if: gearbox-facing inputs and decoder/debug-facing outputs of the block-lock controller.
interface serdes_64b66b_rx_block_lock_if;
    logic        lock_en;
    logic [1:0]  rx_header;
    logic        rx_header_valid;
    logic        rx_block_sync;
    logic        rx_slip;
    logic [2:0]  rx_lock_state;
    logic [15:0] rx_slip_cnt;
    logic [7:0]  rx_lock_loss_cnt;
    logic        rx_hi_ber;
    modport master (
        output lock_en, rx_header, rx_header_valid,
        input  rx_block_sync, rx_slip, rx_lock_state, rx_slip_cnt, rx_lock_loss_cnt, rx_hi_ber
    );
    modport slave (
        input  lock_en, rx_header, rx_header_valid,
        output rx_block_sync, rx_slip, rx_lock_state, rx_slip_cnt, rx_lock_loss_cnt, rx_hi_ber
    );
endinterface

// File: rtl/serdes_64b66b_rx_block_lock.sv
// serdes_64b66b_rx_block_lock: 64B/66B sync-header block lock with gearbox bitslip control.
// Define SERDES_RX_HI_BER_EN to add the 125000-clock high-BER monitor on rx_hi_ber.
module serdes_64b66b_rx_block_lock #(
    parameter int P_SH_CNT_MAX     = 64,
    parameter int P_SH_INVALID_MAX = 16,
    parameter int P_SLIP_WAIT      = 32
) (
    input logic                          pcs_rx_clk,
    input logic                          pcs_rx_rst_n,
    serdes_64b66b_rx_block_lock_if.slave lnk
);
    typedef enum logic [2:0] {
        LOCK_INIT = 3'd0,
        RESET_CNT = 3'd1,
        TEST_SH   = 3'd2,
        GOOD_64   = 3'd3,
        SLIP      = 3'd4,
        SLIP_WAIT = 3'd5
    } state_t;
    localparam logic [6:0] SH_MAX   = 7'(P_SH_CNT_MAX);
    localparam logic [4:0] INV_MAX  = 5'(P_SH_INVALID_MAX);
    localparam logic [7:0] WAIT_MAX = 8'(P_SLIP_WAIT);
    state_t     state, state_nxt;
    logic [6:0] sh_cnt, sh_cnt_nxt;
    logic [4:0] sh_inv_cnt, sh_inv_cnt_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       block_sync_nxt, slip_nxt, hdr_bad;
    assign hdr_bad = lnk.rx_header_valid && (lnk.rx_header[1] == lnk.rx_header[0]);
    always_comb begin
        state_nxt      = state;
        sh_cnt_nxt     = sh_cnt;
        sh_inv_cnt_nxt = sh_inv_cnt;
        wait_cnt_nxt   = wait_cnt;
        block_sync_nxt = lnk.rx_block_sync;
        case (state)
            LOCK_INIT: begin
                block_sync_nxt = 1'b0;
                state_nxt      = RESET_CNT;
            end
            RESET_CNT: begin
                sh_cnt_nxt     = '0;
                sh_inv_cnt_nxt = '0;
                state_nxt      = TEST_SH;
            end
            TEST_SH: if (lnk.rx_header_valid) begin
                sh_cnt_nxt     = sh_cnt + 7'd1;
                sh_inv_cnt_nxt = sh_inv_cnt + {4'd0, hdr_bad};
                // invalid-threshold slip outranks a coincident window end
                if (!lnk.rx_block_sync)
                    state_nxt = hdr_bad ? SLIP : (sh_cnt_nxt == SH_MAX ? GOOD_64 : TEST_SH);
                else
                    state_nxt = sh_inv_cnt_nxt == INV_MAX ? SLIP : (sh_cnt_nxt == SH_MAX ? RESET_CNT : TEST_SH);
            end
            GOOD_64: begin
                block_sync_nxt = 1'b1;
                state_nxt      = RESET_CNT;
            end
            SLIP: begin
                block_sync_nxt = 1'b0;
                wait_cnt_nxt   = WAIT_MAX;
                state_nxt      = SLIP_WAIT;
            end
            SLIP_WAIT: begin
                wait_cnt_nxt = wait_cnt - 8'd1;
                state_nxt    = wait_cnt_nxt == 8'd0 ? RESET_CNT : SLIP_WAIT;
            end
            default: state_nxt = LOCK_INIT;
        endcase
        if (!lnk.lock_en) begin
            state_nxt      = LOCK_INIT;
            block_sync_nxt = 1'b0;
        end
    end
    assign slip_nxt = lnk.lock_en && state == SLIP;
    always_ff @(posedge pcs_rx_clk) begin
        if (!pcs_rx_rst_n) begin
            state                <= LOCK_INIT;
            sh_cnt               <= '0;
            sh_inv_cnt           <= '0;
            wait_cnt             <= '0;
            lnk.rx_block_sync    <= 1'b0;
            lnk.rx_slip          <= 1'b0;
            lnk.rx_slip_cnt      <= '0;
            lnk.rx_lock_loss_cnt <= '0;
        end else begin
            state             <= state_nxt;
            sh_cnt            <= sh_cnt_nxt;
            sh_inv_cnt        <= sh_inv_cnt_nxt;
            wait_cnt          <= wait_cnt_nxt;
            lnk.rx_block_sync <= block_sync_nxt;
            lnk.rx_slip       <= slip_nxt;
            if (slip_nxt && lnk.rx_slip_cnt != 16'hFFFF)
                lnk.rx_slip_cnt <= lnk.rx_slip_cnt + 16'd1;
            if (lnk.rx_block_sync && !block_sync_nxt && lnk.rx_lock_loss_cnt != 8'hFF)
                lnk.rx_lock_loss_cnt <= lnk.rx_lock_loss_cnt + 8'd1;
        end
    end
    assign lnk.rx_lock_state = state;
`ifdef SERDES_RX_HI_BER_EN
    logic [16:0] ber_timer;
    logic [4:0]  ber_cnt;
    logic        hi_ber, ber_expire;
    assign ber_expire = ber_timer == 17'd124999;
    always_ff @(posedge pcs_rx_clk) begin
        if (!pcs_rx_rst_n || !lnk.rx_block_sync) begin
            ber_timer <= '0;
            ber_cnt   <= '0;
            hi_ber    <= 1'b0;
        end else begin
            ber_timer <= ber_expire ? '0 : ber_timer + 17'd1;
            if (ber_expire) begin
                hi_ber  <= ber_cnt >= 5'd16;
                ber_cnt <= '0;
            end else if (hdr_bad && ber_cnt != 5'd16) begin
                ber_cnt <= ber_cnt + 5'd1;
            end
        end
    end
    assign lnk.rx_hi_ber = hi_ber && lnk.rx_block_sync;
`else
    assign lnk.rx_hi_ber = 1'b0;
`endif
endmodule
